t05_htree_merge_engine: RTL and testbench
=========================================

T05_HTREE_MERGE_ENGINE -- requirements
Module: t05_htree_merge_engine

Interface
REQ-001 Parameter IDX_W, default 7, node-index width; tree holds up to 2**IDX_W nodes.
REQ-002 Parameter SUM_W, default 46, frequency-sum width.
REQ-003 Derived: CW=IDX_W+2 (child code width); NODE_W=IDX_W+2*CW+SUM_W (71 at defaults); NULL code={2'b11,IDX_W'b0}.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  merge request; accepted only when busy=0.
REQ-007 least1, least2  in  CW each  child codes: MSB=0 leaf (symbol in low bits); MSB=1 and not NULL is a sum node (index in [IDX_W-1:0]); NULL is empty.
REQ-008 sum  in  SUM_W  combined frequency of both children.
REQ-009 clear  in  1  synchronous: node_cnt:=0, err:=0; ignored while busy=1.
REQ-010 node_valid out 1, node_data out NODE_W, node_ready in 1  new-node write port (valid/ready).
REQ-011 mem_req out 1, mem_we out 1, mem_addr out IDX_W, mem_wdata out NODE_W, mem_rdata in NODE_W, mem_ack in 1  node-memory read-modify-write port.
REQ-012 busy out 1, op_done out 1, tree_done out 1, err out 1, node_cnt out IDX_W.

Function
REQ-013 States: IDLE, EMIT, RD1, WR1, RD2, WR2, FIN.
REQ-014 IDLE with start=1: register least1, least2, sum; later input changes SHALL have no effect on the operation.
REQ-015 Both codes NULL at start: tree_done pulses 1 cycle later; no node emitted; FSM remains IDLE.
REQ-016 Otherwise next state EMIT; busy=1 from the cycle after acceptance until the return to IDLE.
REQ-017 EMIT: node_valid=1, node_data={node_cnt,least1,least2,sum}; hold stable until node_ready=1.
REQ-018 On the node_valid&node_ready cycle: node_cnt increments modulo 2**IDX_W.
REQ-019 If that increment wraps from 2**IDX_W-1 to 0, err SHALL set and stay set until clear or reset.
REQ-020 Exit EMIT to RD1 if least1 is a sum node, else RD2 if least2 is a sum node, else FIN.
REQ-021 RD1/RD2: mem_req=1, mem_we=0, mem_addr=child index; hold until mem_ack; capture mem_rdata on the ack cycle.
REQ-022 WR1/WR2: mem_req=1, mem_we=1, same addr, mem_wdata=captured word with sum field [SUM_W-1:0] forced to 0; hold until mem_ack.
REQ-023 From WR1 go to RD2 if least2 is a sum node, else FIN; from WR2 go to FIN.
REQ-024 mem_req, mem_addr, mem_we and mem_wdata SHALL not change while a request is pending without ack.
REQ-025 FIN: op_done=1 for exactly one cycle; next state IDLE.
REQ-026 Single-symbol case (one code NULL, the other a leaf): tree_done SHALL pulse in the same cycle as op_done.
REQ-027 least1==least2, both sum nodes: perform only the RD1/WR1 update; skip RD2/WR2.
REQ-028 start while busy=1 is ignored; it is not queued.
REQ-029 Minimum latency start to op_done, no sum-node children and node_ready held high: 3 cycles (accept, EMIT, FIN).

Reset
REQ-030 rst_n low: state IDLE; node_cnt, err, busy, op_done, tree_done, node_valid, mem_req, mem_we = 0.
REQ-031 rst_n low: node_data, mem_addr, mem_wdata and captured registers = 0.
REQ-032 Reset mid-operation abandons any pending node or memory transfer; no ack is awaited after release.
REQ-033 First operation after reset uses node index 0.

Verification
REQ-034 Reset, then start with least1=9'h041, least2=9'h042, sum=5, node_ready=1 -> node_data={7'd0,9'h041,9'h042,46'd5}; op_done at cycle 3; node_cnt=1; no mem_req.
REQ-035 least1=9'h103 (sum node 3), least2=9'h042, sum=9; mem_rdata word W; ack after 2 wait cycles -> read addr 3; then write addr 3 with {W[70:46],46'b0}; op_done follows; addr stable throughout the waits.
REQ-036 least1=9'h105, least2=9'h106 -> order RD1(5), WR1(5), RD2(6), WR2(6); least1=least2=9'h105 -> only RD1(5) and WR1(5).
REQ-037 least1=least2=9'h180 -> tree_done pulse, no node_valid; least1=9'h041, least2=9'h180 -> node emitted, then op_done and tree_done in the same cycle.
REQ-038 128 merges with node_ready=1 -> err set on the 128th emission and node_cnt=0; clear -> err=0.
REQ-039 node_ready held low 4 cycles -> node_data stable; start pulsed meanwhile ignored; rst_n asserted mid-RD1 -> all outputs return to reset values.

Source files
------------

// File: rtl/t05_htree_merge_engine.sv
// t05_htree_merge_engine -- Huffman tree merge step: emits a new sum node and clears the sum field of sum-node children.
// Revision 1.0
`default_nettype none

module t05_htree_merge_engine #(
  parameter int IDX_W  = 7,
  parameter int SUM_W  = 46,
  parameter int CW     = IDX_W + 2,
  parameter int NODE_W = IDX_W + 2*CW + SUM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CW-1:0]     least1,
  input  logic [CW-1:0]     least2,
  input  logic [SUM_W-1:0]  sum,
  input  logic              clear,
  output logic              node_valid,
  output logic [NODE_W-1:0] node_data,
  input  logic              node_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [NODE_W-1:0] mem_wdata,
  input  logic [NODE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              op_done,
  output logic              tree_done,
  output logic              err,
  output logic [IDX_W-1:0]  node_cnt
);

  localparam logic [CW-1:0]     NULL_CODE = {2'b11, {IDX_W{1'b0}}};
  localparam logic [NODE_W-1:0] KEEP_MASK = {{(NODE_W-SUM_W){1'b1}}, {SUM_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EMIT = 3'd1,
    RD1  = 3'd2,
    WR1  = 3'd3,
    RD2  = 3'd4,
    WR2  = 3'd5,
    FIN  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      l1_q, l1_d;
  logic [CW-1:0]      l2_q, l2_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   node_cnt_q, node_cnt_d;
  logic               err_q, err_d;
  logic               tree_done_q, tree_done_d;
  logic [NODE_W-1:0]  cap_q, cap_d;

  logic l1_is_sum;
  logic l2_is_sum;
  logic single_sym;

  assign l1_is_sum  = l1_q[CW-1] && (l1_q != NULL_CODE);
  assign l2_is_sum  = l2_q[CW-1] && (l2_q != NULL_CODE);
  assign single_sym = ((l1_q == NULL_CODE) && !l2_q[CW-1]) ||
                      ((l2_q == NULL_CODE) && !l1_q[CW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      l1_q        <= '0;
      l2_q        <= '0;
      sum_q       <= '0;
      node_cnt_q  <= '0;
      err_q       <= 1'b0;
      tree_done_q <= 1'b0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      l1_q        <= l1_d;
      l2_q        <= l2_d;
      sum_q       <= sum_d;
      node_cnt_q  <= node_cnt_d;
      err_q       <= err_d;
      tree_done_q <= tree_done_d;
      cap_q       <= cap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    l1_d        = l1_q;
    l2_d        = l2_q;
    sum_d       = sum_q;
    node_cnt_d  = node_cnt_q;
    err_d       = err_q;
    tree_done_d = 1'b0;
    cap_d       = cap_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          node_cnt_d = '0;
          err_d      = 1'b0;
        end
        if (start) begin
          l1_d  = least1;
          l2_d  = least2;
          sum_d = sum;
          // Two empty children mean the tree is already complete.
          if ((least1 == NULL_CODE) && (least2 == NULL_CODE)) begin
            tree_done_d = 1'b1;
          end else begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (node_ready) begin
          node_cnt_d = node_cnt_q + 1'b1;
          if (node_cnt_q == '1) begin
            err_d = 1'b1;
          end
          if (l1_is_sum)      state_d = RD1;
          else if (l2_is_sum) state_d = RD2;
          else                state_d = FIN;
        end
      end
      RD1: begin
        if (mem_ack) begin
          cap_d   = mem_rdata & KEEP_MASK;
          state_d = WR1;
        end
      end
      WR1: begin
        // Identical children share one node; it is only updated once.
        if (mem_ack) begin
          state_d = (l2_is_sum && (l2_q != l1_q)) ? RD2 : FIN;
        end
      end
      RD2: begin
        if (mem_ack) begin
          cap_d   = mem_rdata & KEEP_MASK;
          state_d = WR2;
        end
      end
      WR2: begin
        if (mem_ack) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign op_done    = (state_q == FIN);
  assign tree_done  = tree_done_q || ((state_q == FIN) && single_sym);
  assign err        = err_q;
  assign node_cnt   = node_cnt_q;
  assign node_valid = (state_q == EMIT);
  assign node_data  = {node_cnt_q, l1_q, l2_q, sum_q};
  assign mem_req    = (state_q == RD1) || (state_q == WR1) ||
                      (state_q == RD2) || (state_q == WR2);
  assign mem_we     = (state_q == WR1) || (state_q == WR2);
  assign mem_addr   = ((state_q == RD1) || (state_q == WR1)) ? l1_q[IDX_W-1:0] :
                      ((state_q == RD2) || (state_q == WR2)) ? l2_q[IDX_W-1:0] : '0;
  assign mem_wdata  = mem_we ? cap_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_t05_htree_merge_engine.sv
// Directed bench for t05_htree_merge_engine with hand-computed expectations.
`default_nettype none

module tb_t05_htree_merge_engine;

  localparam int IDX_W  = 7;
  localparam int SUM_W  = 46;
  localparam int CW     = IDX_W + 2;
  localparam int NODE_W = IDX_W + 2*CW + SUM_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CW-1:0]     least1;
  logic [CW-1:0]     least2;
  logic [SUM_W-1:0]  sum;
  logic              clear;
  logic              node_valid;
  logic [NODE_W-1:0] node_data;
  logic              node_ready;
  logic              mem_req;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_addr;
  logic [NODE_W-1:0] mem_wdata;
  logic [NODE_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic              op_done;
  logic              tree_done;
  logic              err;
  logic [IDX_W-1:0]  node_cnt;

  int total;
  int bad;

  t05_htree_merge_engine #(.IDX_W(IDX_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .least1(least1), .least2(least2),
    .sum(sum), .clear(clear), .node_valid(node_valid), .node_data(node_data),
    .node_ready(node_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .op_done(op_done), .tree_done(tree_done),
    .err(err), .node_cnt(node_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serve one memory request: check it stays put for `waits` cycles, then ack.
  task automatic mem_xfer(input string tag, input logic exp_we, input logic [IDX_W-1:0] exp_addr,
                          input logic [NODE_W-1:0] exp_wdata, input logic [NODE_W-1:0] rdata,
                          input int waits);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, "_req"}, mem_req, 1'b1);
      chk({tag, "_we"}, mem_we, exp_we);
      chk({tag, "_addr"}, mem_addr, exp_addr);
      if (exp_we) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
      if (i == waits) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  logic [NODE_W-1:0] w0;
  logic [NODE_W-1:0] w1;
  logic [NODE_W-1:0] w2;
  logic [NODE_W-1:0] held;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0; start = 1'b0; least1 = '0; least2 = '0; sum = '0; clear = 1'b0;
    node_ready = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    w0 = 71'h12_3456_789A_BCDE_F012;
    w1 = 71'h0A_5A5A_5A5A_5A5A_5A5A;
    w2 = 71'h7F_FFFF_FFFF_FFFF_FFFF;
    tick(); tick();

    chk("rst_busy", busy, 1'b0);
    chk("rst_node_valid", node_valid, 1'b0);
    chk("rst_node_data", node_data, '0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_node_cnt", node_cnt, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_done", {op_done, tree_done}, 2'b00);
    rst_n = 1'b1;
    tick();

    // Leaf + leaf, fastest path.
    start = 1'b1; least1 = 9'h041; least2 = 9'h042; sum = 46'd5; node_ready = 1'b1;
    tick();
    start = 1'b0; least1 = 9'h1FF; least2 = 9'h1FF; sum = 46'd999;
    chk("t1_valid", node_valid, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_data", node_data, {7'd0, 9'h041, 9'h042, 46'd5});
    tick();
    chk("t1_op_done", op_done, 1'b1);
    chk("t1_tree_done", tree_done, 1'b0);
    chk("t1_cnt", node_cnt, 7'd1);
    chk("t1_no_mem", mem_req, 1'b0);
    tick();
    chk("t1_idle", {busy, op_done}, 2'b00);

    // Sum-node child 3 with a slow memory.
    start = 1'b1; least1 = 9'h103; least2 = 9'h042; sum = 46'd9;
    tick();
    start = 1'b0;
    chk("t2_data", node_data, {7'd1, 9'h103, 9'h042, 46'd9});
    tick();
    mem_xfer("t2_rd", 1'b0, 7'd3, '0, w0, 2);
    mem_xfer("t2_wr", 1'b1, 7'd3, {w0[70:46], 46'b0}, '0, 1);
    chk("t2_op_done", op_done, 1'b1);
    chk("t2_mem_idle", mem_req, 1'b0);
    tick();

    // Two distinct sum-node children.
    start = 1'b1; least1 = 9'h105; least2 = 9'h106; sum = 46'd3;
    tick();
    start = 1'b0;
    tick();
    mem_xfer("t3_rd1", 1'b0, 7'd5, '0, w1, 0);
    mem_xfer("t3_wr1", 1'b1, 7'd5, {w1[70:46], 46'b0}, '0, 0);
    mem_xfer("t3_rd2", 1'b0, 7'd6, '0, w2, 1);
    mem_xfer("t3_wr2", 1'b1, 7'd6, {w2[70:46], 46'b0}, '0, 0);
    chk("t3_op_done", op_done, 1'b1);
    tick();

    // Identical sum-node children: one update only.
    start = 1'b1; least1 = 9'h105; least2 = 9'h105; sum = 46'd4;
    tick();
    start = 1'b0;
    tick();
    mem_xfer("t4_rd1", 1'b0, 7'd5, '0, w2, 0);
    mem_xfer("t4_wr1", 1'b1, 7'd5, {w2[70:46], 46'b0}, '0, 0);
    chk("t4_op_done", op_done, 1'b1);
    chk("t4_no_rd2", mem_req, 1'b0);
    chk("t4_cnt", node_cnt, 7'd4);
    tick();

    // Both NULL: immediate tree_done, no node.
    start = 1'b1; least1 = 9'h180; least2 = 9'h180; sum = 46'd0;
    tick();
    start = 1'b0;
    chk("t5_tree_done", tree_done, 1'b1);
    chk("t5_no_node", {node_valid, busy}, 2'b00);
    tick();
    chk("t5_tree_pulse", tree_done, 1'b0);

    // Single symbol: op_done and tree_done together.
    start = 1'b1; least1 = 9'h041; least2 = 9'h180; sum = 46'd1;
    tick();
    start = 1'b0;
    chk("t6_valid", node_valid, 1'b1);
    chk("t6_tree_early", tree_done, 1'b0);
    tick();
    chk("t6_done_pair", {op_done, tree_done}, 2'b11);
    tick();
    chk("t6_after", tree_done, 1'b0);

    // Backpressure with an ignored start during busy.
    node_ready = 1'b0;
    start = 1'b1; least1 = 9'h041; least2 = 9'h042; sum = 46'd7;
    tick();
    held = {7'd5, 9'h041, 9'h042, 46'd7};
    for (int i = 0; i < 4; i++) begin
      start = i[0]; least1 = 9'h043; least2 = 9'h044; sum = 46'd77;
      chk("t7_valid", node_valid, 1'b1);
      chk("t7_stable", node_data, held);
      tick();
    end
    start = 1'b0; node_ready = 1'b1;
    chk("t7_stable_last", node_data, held);
    tick();
    chk("t7_op_done", op_done, 1'b1);
    tick();
    tick();
    chk("t7_not_queued", {busy, node_valid}, 2'b00);
    chk("t7_cnt", node_cnt, 7'd6);

    // Wrap of the node counter.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t8_clear_cnt", node_cnt, 7'd0);
    for (int i = 0; i < 128; i++) begin
      start = 1'b1; least1 = 9'h041; least2 = 9'h042; sum = 46'd2;
      tick();
      start = 1'b0;
      tick();
      if (i == 126) chk("t8_err_before", err, 1'b0);
      tick();
    end
    chk("t8_err_set", err, 1'b1);
    chk("t8_cnt_wrap", node_cnt, 7'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t8_err_clear", err, 1'b0);

    // Reset in the middle of a read.
    start = 1'b1; least1 = 9'h10A; least2 = 9'h042; sum = 46'd6;
    tick();
    start = 1'b0;
    tick();
    chk("t9_in_rd1", {mem_req, mem_addr}, {1'b1, 7'd10});
    rst_n = 1'b0;
    #1;
    chk("t9_rst_mem", {mem_req, mem_we, mem_addr}, '0);
    chk("t9_rst_ctl", {busy, node_valid, op_done, tree_done, err}, '0);
    chk("t9_rst_data", node_data, '0);
    chk("t9_rst_cnt", node_cnt, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t9_idle_after", {busy, mem_req}, 2'b00);
    start = 1'b1; least1 = 9'h041; least2 = 9'h042; sum = 46'd8;
    tick();
    start = 1'b0;
    chk("t9_first_idx0", node_data, {7'd0, 9'h041, 9'h042, 46'd8});
    tick();
    chk("t9_op_done", op_done, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
